// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_flash_responder
//
// SPI mode-0 responder that behaves like a minimal serial flash. It decodes the
// opcode shifted in on MOSI and answers on MISO from a byte-wide memory port,
// from a fixed JEDEC ID, or with a constant status byte. All SPI pins are
// oversampled in the CLK_40 domain, so nothing here is clocked by SPI_clk.
//
// Supported opcodes:
//   8'h03 READ : three address bytes, then sequential data until deselect
//   8'h9F RDID : JEDEC_ID bytes MSB first, repeating every three bytes
//   8'h05 RDSR : status byte 8'h00, repeating
//   other      : cmd_error pulse, MISO held high until deselect
//
// Ports:
//   CLK_40       in   system clock, the only clock in the block
//   reset        in   asynchronous, active-high reset
//   SPI_clk      in   serial clock from the initiator, idles low
//   chip_select  in   active-low select from the initiator
//   MOSI         in   serial data in, MSB first
//   MISO         out  serial data out, MSB first, 1 when idle
//   mem_rd_en    out  one-cycle read request for the byte at mem_addr
//   mem_addr     out  byte address of the current request
//   mem_rd_data  in   byte returned MEM_LATENCY cycles after mem_rd_en
//   busy         out  1 while a transaction is selected
//   cmd_error    out  one-cycle pulse on an unsupported opcode
//
// The initiator must hold each SPI_clk phase for at least
// SYNC_STAGES + MEM_LATENCY + 3 CLK_40 cycles so a fetched byte is loaded
// before the falling edge that starts shifting it out.
// -----------------------------------------------------------------------------
module spi_flash_responder #(
    parameter int          ADDR_W      = 24,
    parameter int          SYNC_STAGES = 2,
    parameter int          MEM_LATENCY = 1,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              SPI_clk,
    input  logic              chip_select,
    input  logic              MOSI,
    output logic              MISO,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              cmd_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_STATUS,
        S_IGNORE
    } state_t;

    // Address as received is 24 bits; widen (zero-extend) when ADDR_W is larger.
    localparam int AW_EXT = (ADDR_W > 24) ? ADDR_W : 24;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    // NOTE: every clocked assignment uses <= so all flops sample the values
    // from before the edge; blocking here would collapse the synchronizer chain.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;      // reset into the deselected state
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk, w_cs, w_mosi;
    logic w_rise, w_fall, w_cs_fall;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    assign w_cs_fall = ~w_cs & r_cs_d;

    // ---------------------------------------------------------------- state
    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_rx;
    logic [7:0]            r_tx;
    logic [15:0]           r_addr_acc;
    logic [1:0]            r_addr_bytes;
    logic [1:0]            r_id_idx;
    logic [MEM_LATENCY-1:0] r_rd_pipe;
    logic                  r_miso;
    logic                  r_mem_rd_en;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_busy;
    logic                  r_cmd_error;

    assign MISO      = r_miso;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign busy      = r_busy;
    assign cmd_error = r_cmd_error;

    // ---------------------------------------------------------------- comb
    state_t             w_cur_state;
    logic [7:0]         w_rx_byte;
    logic               w_byte_done;
    logic [AW_EXT-1:0]  w_addr_ext;
    logic [MEM_LATENCY:0] w_pipe_next;
    logic [7:0]         w_id_byte;
    logic               w_tx_state;

    // A select and a clock edge seen in the same cycle: treat the select as
    // already applied so the edge is handled in CMD.
    assign w_cur_state = (r_state == S_IDLE && w_cs_fall) ? S_CMD : r_state;
    assign w_rx_byte   = {r_rx[6:0], w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_addr_ext  = AW_EXT'({r_addr_acc, w_rx_byte});
    // Bit MEM_LATENCY-1 marks the cycle in which mem_rd_data is valid.
    assign w_pipe_next = {r_rd_pipe, r_mem_rd_en};
    assign w_tx_state  = (w_cur_state == S_DATA) || (w_cur_state == S_ID) ||
                         (w_cur_state == S_STATUS);

    // NOTE: a default assignment ahead of the case keeps this purely
    // combinational; an uncovered path would otherwise infer a latch.
    always_comb begin
        w_id_byte = JEDEC_ID[7:0];
        case (r_id_idx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            default: w_id_byte = JEDEC_ID[7:0];
        endcase
    end

    // ---------------------------------------------------------------- fsm
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_addr_acc   <= 16'h0000;
            r_addr_bytes <= 2'd0;
            r_id_idx     <= 2'd0;
            r_rd_pipe    <= '0;
            r_miso       <= 1'b1;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_cmd_error <= 1'b0;
            r_rd_pipe   <= w_pipe_next[MEM_LATENCY-1:0];

            if (w_cs) begin
                // Deselected: abandon everything, including an in-flight fetch.
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_miso       <= 1'b1;
                r_bit_cnt    <= 3'd0;
                r_rx         <= 8'h00;
                r_tx         <= 8'h00;
                r_addr_acc   <= 16'h0000;
                r_addr_bytes <= 2'd0;
                r_id_idx     <= 2'd0;
                r_rd_pipe    <= '0;
            end else if (w_cur_state != S_IDLE) begin
                if (r_state == S_IDLE) begin
                    r_state <= S_CMD;
                    r_busy  <= 1'b1;
                end

                if (w_fall) begin
                    if (w_tx_state) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b1;
                    end
                end

                // Fetched byte arrives between SPI edges (guaranteed by the
                // minimum phase length), ready for the next falling edge.
                if (r_rd_pipe[MEM_LATENCY-1]) begin
                    r_tx <= mem_rd_data;
                end

                if (w_rise) begin
                    r_rx      <= w_rx_byte;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_done) begin
                        case (w_cur_state)
                            S_CMD: begin
                                case (w_rx_byte)
                                    8'h03: begin
                                        r_state      <= S_ADDR;
                                        r_addr_bytes <= 2'd0;
                                    end
                                    8'h9F: begin
                                        r_state  <= S_ID;
                                        r_tx     <= JEDEC_ID[23:16];
                                        r_id_idx <= 2'd1;
                                    end
                                    8'h05: begin
                                        r_state <= S_STATUS;
                                        r_tx    <= 8'h00;
                                    end
                                    default: begin
                                        r_state     <= S_IGNORE;
                                        r_cmd_error <= 1'b1;
                                    end
                                endcase
                            end
                            S_ADDR: begin
                                if (r_addr_bytes == 2'd2) begin
                                    r_state     <= S_DATA;
                                    r_mem_addr  <= w_addr_ext[ADDR_W-1:0];
                                    r_mem_rd_en <= 1'b1;
                                end else begin
                                    r_addr_acc   <= {r_addr_acc[7:0], w_rx_byte};
                                    r_addr_bytes <= r_addr_bytes + 2'd1;
                                end
                            end
                            S_DATA: begin
                                // Prefetch the next sequential byte; wraps at 2^ADDR_W.
                                r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                                r_mem_rd_en <= 1'b1;
                            end
                            S_ID: begin
                                r_tx     <= w_id_byte;
                                r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
                            end
                            S_STATUS: begin
                                r_tx <= 8'h00;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
//
// Directed bench for spi_flash_responder. A bit-banged mode-0 initiator drives
// the SPI pins on the falling CLK_40 edge; a memory model returns
// addr[7:0] ^ 8'hA5 one cycle after each mem_rd_en and logs request addresses.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

    logic        CLK_40;
    logic        reset;
    logic        SPI_clk;
    logic        chip_select;
    logic        MOSI;
    logic        MISO;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        busy;
    logic        cmd_error;

    int checks;
    int failures;
    int half;

    spi_flash_responder dut (
        .CLK_40      (CLK_40),
        .reset       (reset),
        .SPI_clk     (SPI_clk),
        .chip_select (chip_select),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .cmd_error   (cmd_error)
    );

    initial CLK_40 = 1'b0;
    always #5 CLK_40 = ~CLK_40;

    // ------------------------------------------------------- memory model
    logic        mem_pend;
    logic [23:0] mem_paddr;
    logic [23:0] log_q[$];
    int          err_cycles;

    initial begin
        mem_pend    = 1'b0;
        mem_paddr   = 24'h0;
        mem_rd_data = 8'h00;
        err_cycles  = 0;
    end

    always @(negedge CLK_40) begin
        if (mem_rd_en) begin
            log_q.push_back(mem_addr);
            mem_pend  <= 1'b1;
            mem_paddr <= mem_addr;
        end else begin
            mem_pend <= 1'b0;
        end
        if (cmd_error) err_cycles = err_cycles + 1;
    end

    always @(posedge CLK_40) begin
        if (mem_pend) mem_rd_data <= mem_paddr[7:0] ^ 8'hA5;
    end

    // ------------------------------------------------------- SPI initiator
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_40);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            wait_cyc(half);
            SPI_clk = 1'b1;
            rx = {rx[6:0], MISO};
            wait_cyc(half);
            SPI_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        chip_select = 1'b0;
        wait_cyc(half);
    endtask

    task automatic cs_high();
        wait_cyc(half);
        chip_select = 1'b1;
        MOSI = 1'b0;
        wait_cyc(half + 8);
    endtask

    task automatic send_read_cmd(input logic [23:0] addr);
        logic [7:0] rx;
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(addr[23:16], rx);
        spi_byte(addr[15:8], rx);
        spi_byte(addr[7:0], rx);
    endtask

    task automatic clear_logs();
        log_q.delete();
        err_cycles = 0;
    endtask

    // ------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", MISO); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
        checks++; if (mem_addr !== 24'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000000", mem_addr); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL reset_cmd_error got=%b exp=0", cmd_error); end
        reset = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_read();
        logic [7:0] exp_b [4];
        logic [7:0] rx;
        exp_b = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        clear_logs();
        send_read_cmd(24'h000010);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp_b[i]) begin failures++; $display("FAIL read_byte%0d got=%h exp=%h", i, rx, exp_b[i]); end
        end
        cs_high();
        checks++; if (log_q.size() != 5) begin failures++; $display("FAIL read_pulses got=%0d exp=5", log_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= log_q.size()) begin
                failures++; $display("FAIL read_addr%0d got=none exp=%h", i, 24'h10 + i);
            end else if (log_q[i] !== 24'(24'h10 + i)) begin
                failures++; $display("FAIL read_addr%0d got=%h exp=%h", i, log_q[i], 24'h10 + i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_b [3];
        logic [23:0] exp_a [3];
        logic [7:0]  rx;
        exp_b = '{8'h5B, 8'h5A, 8'hA5};
        exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
        clear_logs();
        send_read_cmd(24'hFFFFFE);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp_b[i]) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, rx, exp_b[i]); end
        end
        cs_high();
        checks++; if (log_q.size() != 4) begin failures++; $display("FAIL wrap_pulses got=%0d exp=4", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= log_q.size()) begin
                failures++; $display("FAIL wrap_addr%0d got=none exp=%h", i, exp_a[i]);
            end else if (log_q[i] !== exp_a[i]) begin
                failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, log_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_rdid_rdsr();
        logic [7:0] exp_id [6];
        logic [7:0] rx;
        exp_id = '{8'hEF, 8'h40, 8'h18, 8'hEF, 8'h40, 8'h18};
        cs_low();
        spi_byte(8'h9F, rx);
        for (int i = 0; i < 6; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp_id[i]) begin failures++; $display("FAIL rdid_byte%0d got=%h exp=%h", i, rx, exp_id[i]); end
        end
        cs_high();
        cs_low();
        spi_byte(8'h05, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'hFF, rx);
            checks++;
            if (rx !== 8'h00) begin failures++; $display("FAIL rdsr_byte%0d got=%h exp=00", i, rx); end
        end
        cs_high();
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx;
        clear_logs();
        cs_low();
        spi_byte(8'hAB, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== 8'hFF) begin failures++; $display("FAIL bad_miso%0d got=%h exp=ff", i, rx); end
        end
        cs_high();
        checks++; if (err_cycles != 1) begin failures++; $display("FAIL bad_err_cycles got=%0d exp=1", err_cycles); end
        checks++; if (log_q.size() != 0) begin failures++; $display("FAIL bad_rd_en got=%0d exp=0", log_q.size()); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        send_read_cmd(24'h000020);
        spi_bits(8'h00, 4, rx);   // data 0x20^A5 = 85, first nibble 1000
        checks++; if (rx[3:0] !== 4'b1000) begin failures++; $display("FAIL abort_nibble got=%b exp=1000", rx[3:0]); end
        cs_high();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL abort_miso got=%b exp=1", MISO); end
        cs_low();
        spi_byte(8'h9F, rx);
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'hEF) begin failures++; $display("FAIL abort_rdid got=%h exp=ef", rx); end
        cs_high();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        send_read_cmd(24'h000050);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 3, rx);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL rstmid_miso got=%b exp=1", MISO); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en got=%b exp=0", mem_rd_en); end
        chip_select = 1'b1;
        SPI_clk = 1'b0;
        MOSI = 1'b0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(6);
        send_read_cmd(24'h000050);
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'hF5) begin failures++; $display("FAIL rstmid_after got=%h exp=f5", rx); end
        cs_high();
    endtask

    task automatic test_sweep();
        int         halves [4];
        logic [7:0] rx;
        halves = '{20, 12, 8, 6};
        for (int h = 0; h < 4; h++) begin
            half = halves[h];
            send_read_cmd(24'h000040);
            spi_byte(8'h00, rx);
            checks++; if (rx !== 8'hE5) begin failures++; $display("FAIL sweep_h%0d_b0 got=%h exp=e5", half, rx); end
            spi_byte(8'h00, rx);
            checks++; if (rx !== 8'hE4) begin failures++; $display("FAIL sweep_h%0d_b1 got=%h exp=e4", half, rx); end
            cs_high();
        end
        half = 8;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        half        = 8;
        reset       = 1'b1;
        SPI_clk     = 1'b0;
        chip_select = 1'b1;
        MOSI        = 1'b0;

        test_reset();
        test_read();
        test_wrap();
        test_rdid_rdsr();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        test_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
